// File: rtl/if_fetch_unit.sv
// if_fetch_unit: miniLA instruction-fetch stage. One outstanding IROM request,
// buffered instruction handed to decode over a valid/ready handshake.
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_rvalid,
    input  logic [31:0] irom_rdata,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_adef
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] inst_nx, ipc_nx;
    logic        adef_nx;
    logic        req_nx, valid_nx;
    logic        req_block;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            irom_req <= 1'b0;
            if_valid <= 1'b0;
            if_inst  <= 32'd0;
            if_pc    <= 32'd0;
            if_adef  <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            irom_req <= req_nx;
            if_valid <= valid_nx;
            if_inst  <= inst_nx;
            if_pc    <= ipc_nx;
            if_adef  <= adef_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        inst_nx   = if_inst;
        ipc_nx    = if_pc;
        adef_nx   = if_adef;
        req_block = 1'b0;
        case (state)
            S_BOOT: state_nx = S_WAIT;
            S_WAIT: begin
                if (redirect) begin
                    // Only a request still awaiting its response needs draining;
                    // irom_req is low for one cycle after any redirect here.
                    pc_nx     = redirect_pc;
                    req_block = 1'b1;
                    if (irom_req && !irom_rvalid)
                        state_nx = S_DROP;
                end else if (pc[1:0] != 2'b00) begin
                    inst_nx  = NOP_INST;
                    ipc_nx   = pc;
                    adef_nx  = 1'b1;
                    state_nx = S_HOLD;
                end else if (irom_req && irom_rvalid) begin
                    inst_nx  = irom_rdata;
                    ipc_nx   = pc;
                    adef_nx  = 1'b0;
                    state_nx = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect)
                    pc_nx = redirect_pc;
                if (irom_rvalid)
                    state_nx = S_WAIT;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    state_nx = S_WAIT;
                end else if (id_ready) begin
                    pc_nx    = if_pc + 32'd4;
                    state_nx = S_WAIT;
                end
            end
            default: state_nx = S_BOOT;
        endcase
        req_nx   = (state_nx == S_WAIT) && (pc_nx[1:0] == 2'b00) && !req_block;
        valid_nx = (state_nx == S_HOLD);
    end

    assign irom_addr = pc;
    assign if_pc4    = if_pc + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle-by-cycle vectors for if_fetch_unit plus a
// hand-written async-reset / late-response sequence.
`default_nettype none

module tb_if_fetch_unit;

    localparam logic [31:0] R    = 32'h1C00_0000;
    localparam logic [31:0] NOP  = 32'h0340_0000;
    localparam logic [31:0] A4   = 32'h1C00_0004;
    localparam logic [31:0] A8   = 32'h1C00_0008;
    localparam logic [31:0] A40  = 32'h1C00_0040;
    localparam logic [31:0] A42  = 32'h1C00_0042;
    localparam logic [31:0] A100 = 32'h1C00_0100;
    localparam logic [31:0] A200 = 32'h1C00_0200;
    localparam logic [31:0] TOP  = 32'hFFFF_FFFC;
    localparam logic [31:0] I1   = 32'h1111_0001;
    localparam logic [31:0] I2   = 32'h2222_0002;
    localparam logic [31:0] I3   = 32'h3333_0003;
    localparam logic [31:0] I4   = 32'h4444_0004;
    localparam logic [31:0] I5   = 32'h5555_0005;
    localparam logic [31:0] I6   = 32'h6666_0006;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
    localparam int NV = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_rvalid = 1'b0;
    logic [31:0] irom_rdata = 32'd0;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_adef;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .cpu_clk     (clk),
        .cpu_rst_n   (rst_n),
        .irom_req    (irom_req),
        .irom_addr   (irom_addr),
        .irom_rvalid (irom_rvalid),
        .irom_rdata  (irom_rdata),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_adef     (if_adef)
    );

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_adef;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rdata,
                                input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr, input logic e_val,
                                input logic [31:0] e_inst, input logic [31:0] e_pc,
                                input logic e_adef);
        vec_t v;
        v.rst_n = r;     v.rv = rv;         v.rdata = rdata;
        v.rdy = rdy;     v.rd = rd;         v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_inst = e_inst; v.e_pc = e_pc;   v.e_adef = e_adef;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h, want %h", idx, name, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_val, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic e_adef);
        logic [31:0] e_pc4;
        e_pc4 = e_pc + 32'd4;
        chk("irom_req",  idx, {31'd0, irom_req}, {31'd0, e_req});
        chk("irom_addr", idx, irom_addr, e_addr);
        chk("if_valid",  idx, {31'd0, if_valid}, {31'd0, e_val});
        chk("if_inst",   idx, if_inst, e_inst);
        chk("if_pc",     idx, if_pc, e_pc);
        chk("if_pc4",    idx, if_pc4, e_pc4);
        chk("if_adef",   idx, {31'd0, if_adef}, {31'd0, e_adef});
    endtask

    initial begin
        bit got;
        // reset, boot, latency-1 fetch with id_ready high
        tbl[0]  = mk(0,0,0,   0,0,0,    0,R,   0,0,  0,   0);
        tbl[1]  = mk(1,0,0,   0,0,0,    0,R,   0,0,  0,   0);
        tbl[2]  = mk(1,0,0,   1,0,0,    1,R,   0,0,  0,   0);
        tbl[3]  = mk(1,1,I1,  1,0,0,    1,R,   0,0,  0,   0);
        tbl[4]  = mk(1,0,0,   1,0,0,    0,R,   1,I1, R,   0);
        tbl[5]  = mk(1,0,0,   0,0,0,    1,A4,  0,I1, R,   0);
        tbl[6]  = mk(1,1,I2,  0,0,0,    1,A4,  0,I1, R,   0);
        // five cycles of backpressure; a stray rvalid in HOLD is ignored
        tbl[7]  = mk(1,0,0,   0,0,0,    0,A4,  1,I2, A4,  0);
        tbl[8]  = mk(1,1,BAD, 0,0,0,    0,A4,  1,I2, A4,  0);
        tbl[9]  = mk(1,0,0,   0,0,0,    0,A4,  1,I2, A4,  0);
        tbl[10] = mk(1,0,0,   0,0,0,    0,A4,  1,I2, A4,  0);
        tbl[11] = mk(1,0,0,   0,0,0,    0,A4,  1,I2, A4,  0);
        tbl[12] = mk(1,0,0,   1,0,0,    0,A4,  1,I2, A4,  0);
        // redirect while a latency-3 fetch is outstanding
        tbl[13] = mk(1,0,0,   0,0,0,    1,A8,  0,I2, A4,  0);
        tbl[14] = mk(1,0,0,   0,1,A100, 1,A8,  0,I2, A4,  0);
        tbl[15] = mk(1,0,0,   0,0,0,    0,A100,0,I2, A4,  0);
        tbl[16] = mk(1,1,BAD, 0,0,0,    0,A100,0,I2, A4,  0);
        tbl[17] = mk(1,0,0,   0,0,0,    1,A100,0,I2, A4,  0);
        tbl[18] = mk(1,1,I3,  0,0,0,    1,A100,0,I2, A4,  0);
        // redirect and id_ready together in HOLD
        tbl[19] = mk(1,0,0,   1,1,A40,  0,A100,1,I3, A100,0);
        tbl[20] = mk(1,0,0,   0,0,0,    1,A40, 0,I3, A100,0);
        // redirect coinciding with rvalid: response dropped, one idle req cycle
        tbl[21] = mk(1,1,BAD, 0,1,A200, 1,A40, 0,I3, A100,0);
        tbl[22] = mk(1,0,0,   0,0,0,    0,A200,0,I3, A100,0);
        tbl[23] = mk(1,0,0,   0,0,0,    1,A200,0,I3, A100,0);
        tbl[24] = mk(1,1,I4,  0,0,0,    1,A200,0,I3, A100,0);
        // misaligned redirect target -> NOP with address error
        tbl[25] = mk(1,0,0,   0,1,A42,  0,A200,1,I4, A200,0);
        tbl[26] = mk(1,0,0,   0,0,0,    0,A42, 0,I4, A200,0);
        tbl[27] = mk(1,0,0,   0,0,0,    0,A42, 1,NOP,A42, 1);
        // fetch at the top of the address space, pc wraps to 0
        tbl[28] = mk(1,0,0,   1,1,TOP,  0,A42, 1,NOP,A42, 1);
        tbl[29] = mk(1,0,0,   0,0,0,    1,TOP, 0,NOP,A42, 1);
        tbl[30] = mk(1,1,I5,  0,0,0,    1,TOP, 0,NOP,A42, 1);
        tbl[31] = mk(1,0,0,   1,0,0,    0,TOP, 1,I5, TOP, 0);
        tbl[32] = mk(1,0,0,   0,0,0,    1,32'd0,0,I5,TOP, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n       = tbl[i].rst_n;
            irom_rvalid = tbl[i].rv;
            irom_rdata  = tbl[i].rdata;
            id_ready    = tbl[i].rdy;
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            #1;
            chk_all(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_inst,
                    tbl[i].e_pc, tbl[i].e_adef);
        end

        // async reset mid-cycle with a request pending
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all(100, 1'b0, R, 1'b0, 32'd0, 32'd0, 1'b0);
        // late response lands in BOOT and must be ignored
        @(negedge clk);
        rst_n       = 1'b1;
        irom_rvalid = 1'b1;
        irom_rdata  = BAD;
        #1 chk_all(101, 1'b0, R, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        irom_rvalid = 1'b0;
        #1 chk_all(102, 1'b1, R, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        irom_rvalid = 1'b1;
        irom_rdata  = I6;
        id_ready    = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            irom_rvalid = 1'b0;
            #1;
            if (if_valid) got = 1'b1;
        end
        chk("restart_valid", 103, {31'd0, got}, 32'd1);
        chk("restart_inst", 103, if_inst, I6);
        chk("restart_pc", 103, if_pc, R);
        chk("restart_pc4", 103, if_pc4, A4);
        chk("restart_adef", 103, {31'd0, if_adef}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the miniLA core, directly upstream of decode and the immediate sign-extender.
- Holds the PC and fetches one 32-bit word per instruction from the IROM through a req/rvalid handshake.
- Presents the buffered instruction word (the sign-extender's `din` source) plus its PC to decode with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute, including cancellation of an in-flight fetch.

Parameters:
- RESET_PC, 32'h1C00_0000, PC loaded on reset.
- NOP_INST, 32'h0340_0000, instruction word presented on an address-error fetch (andi r0,r0,0).

Ports:
- cpu_clk  in  1  core clock; all state on rising edge.
- cpu_rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is the top level's job.
- irom_req  out  1  fetch request; held high until response.
- irom_addr  out  32  fetch byte address (= internal pc).
- irom_rvalid  in  1  response valid for the outstanding request.
- irom_rdata  in  32  instruction word, valid with irom_rvalid.
- id_ready  in  1  decode accepts the instruction this cycle.
- redirect  in  1  single-cycle redirect strobe from execute.
- redirect_pc  in  32  redirect target.
- if_valid  out  1  if_inst/if_pc valid.
- if_inst  out  32  fetched instruction word.
- if_pc  out  32  PC of if_inst.
- if_pc4  out  32  if_pc + 4, modulo 2^32.
- if_adef  out  1  address-error flag for this fetch.

Behaviour:
- Reset values:
  - state S_BOOT, pc = RESET_PC.
  - irom_req = 0, if_valid = 0, if_inst = 0, if_pc = 0, if_adef = 0.
  - if_pc4 is combinational from if_pc, so it resets to 4.
- All outputs are registered except if_pc4 and irom_addr (= pc).
- S_BOOT: one cycle, irom_req = 0, always goes to S_WAIT. This keeps the first request off the cycle reset deasserts.
- S_WAIT, pc[1:0] == 0:
  - Drives irom_req = 1 and irom_addr = pc. Both stay stable until rvalid or redirect.
  - irom_rvalid is never asserted in the first req cycle; minimum latency is 1 cycle.
  - Priority, highest first:
    - redirect with rvalid in the same cycle: response discarded, pc <= redirect_pc, stay in S_WAIT. irom_req drops for exactly one cycle.
    - redirect without rvalid: pc <= redirect_pc, go to S_DROP.
    - rvalid: if_inst <= irom_rdata, if_pc <= pc, if_adef <= 0, go to S_HOLD.
- S_WAIT, pc[1:0] != 0:
  - No request is issued; irom_req = 0.
  - Next cycle: if_inst <= NOP_INST, if_pc <= pc, if_adef <= 1, go to S_HOLD.
  - A redirect in this cycle overrides: pc <= redirect_pc, stay in S_WAIT.
- S_DROP:
  - irom_req = 0; waits for the stale response.
  - On rvalid: data discarded, go to S_WAIT.
  - redirect while in S_DROP updates pc and stays in S_DROP. Last redirect wins.
- S_HOLD:
  - if_valid = 1; if_inst, if_pc and if_adef stay stable while id_ready = 0.
  - redirect (wins over id_ready): pc <= redirect_pc, go to S_WAIT. The held instruction is discarded even if id_ready = 1 that cycle; decode must not commit it.
  - Otherwise id_ready: pc <= if_pc + 4, go to S_WAIT.
  - if_valid deasserts on the next edge.
- Throughput: 1 instruction per (IROM latency + 2) cycles minimum. There is no speculative prefetch and at most one IROM request is outstanding.
- PC wrap: pc + 4 from 32'hFFFF_FFFC wraps to 0; no error is flagged.
- irom_rvalid in S_BOOT or S_HOLD is a protocol violation and is ignored.
- Reset mid-operation: asynchronous return to reset values. Any IROM response arriving after reset deasserts lands in S_BOOT and is ignored.

Test Plan:
- Reset release, IROM latency 1, id_ready = 1:
  - irom_req asserts on cycle 2 with addr 1C00_0000.
  - First if_valid shows pc 1C00_0000, if_pc4 1C00_0004.
  - Next request addr is 1C00_0004.
- Backpressure: id_ready = 0 for 5 cycles in S_HOLD -> if_valid, if_inst and if_pc stable all 5 cycles; no irom_req. Releasing id_ready -> next request at pc+4.
- Redirect during outstanding fetch:
  - Latency-3 IROM; redirect = 1, redirect_pc = 1C00_0100 on the cycle after req.
  - Stale rvalid is discarded with no if_valid.
  - Next request addr is 1C00_0100.
- Simultaneous redirect and id_ready in S_HOLD, redirect_pc 1C00_0040 -> held instruction not accepted; next irom_addr is 1C00_0040, not pc+4.
- Misaligned redirect_pc 1C00_0042 -> no irom_req; if_valid with if_inst 0340_0000, if_adef 1, if_pc 1C00_0042.
- Async reset asserted in S_WAIT with a response pending -> outputs zero immediately. After release, the late rvalid is ignored and the fetch restarts at RESET_PC.
